// File: rtl/pipe_reg_elastic.sv
// pipe_reg_elastic: DEPTH-stage valid/ready pipeline register with bubble collapse,
// optional input skid buffer (registered in_ready) and synchronous flush.
module pipe_reg_elastic #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int REG_READY = 1,
  parameter logic [WIDTH-1:0] RST_DATA = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic in_ready,
  output logic out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic out_ready,
  output logic [$clog2(DEPTH+2)-1:0] occupancy
);
  localparam int OW = $clog2(DEPTH+2);
  logic [DEPTH-1:0] v_q, v_d, adv, src_v;
  logic [DEPTH-1:0][WIDTH-1:0] d_q, d_d, src_d;
  logic skid_v_q, skid_v_d, skid_load, in_xfer, out_xfer, s0_v, run;
  logic [WIDTH-1:0] skid_d_q, skid_d_d, s0_d;
  logic [OW-1:0] occ_q, occ_d;
  // A stage may load when any stage at or ahead of it is empty, or the head is leaving
  always_comb begin
    run = out_ready;
    adv = '0;
    for (int i = DEPTH-1; i >= 0; i--) begin
      run = run | !v_q[i];
      adv[i] = run;
    end
  end
  assign in_ready  = !rst && !flush && (REG_READY != 0 ? !skid_v_q : adv[0]);
  assign in_xfer   = in_valid && in_ready;
  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign out_xfer  = out_valid && out_ready;
  assign occupancy = occ_q;
  assign s0_v      = skid_v_q || in_xfer;
  assign s0_d      = skid_v_q ? skid_d_q : in_data;
  assign src_v     = DEPTH'({v_q, s0_v});
  assign src_d     = (DEPTH*WIDTH)'({d_q, s0_d});
  assign skid_load = REG_READY != 0 && in_xfer && !adv[0];
  always_comb begin
    v_d = flush ? '0 : v_q;
    d_d = d_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (adv[i] && !flush) v_d[i] = src_v[i];
      if (adv[i] && src_v[i] && !flush) d_d[i] = src_d[i];
    end
  end
  assign skid_v_d = !flush && (skid_load || (skid_v_q && !adv[0]));
  assign skid_d_d = skid_load ? in_data : skid_d_q;
  assign occ_d    = flush ? '0 : occ_q + OW'(in_xfer) - OW'(out_xfer);
  always_ff @(posedge clk) begin
    if (rst) begin
      v_q      <= '0;
      d_q      <= {DEPTH{RST_DATA}};
      skid_v_q <= 1'b0;
      skid_d_q <= RST_DATA;
      occ_q    <= '0;
    end else begin
      v_q      <= v_d;
      d_q      <= d_d;
      skid_v_q <= skid_v_d;
      skid_d_q <= skid_d_d;
      occ_q    <= occ_d;
    end
  end
endmodule

// File: tb/tb_pipe_reg_elastic.sv
// tb_pipe_reg_elastic: several parameterisations side by side, each checked every cycle
// against a positional queue model, plus directed literal expectations.
module tb_pipe_reg_elastic;
  localparam int NI = 6;
  localparam int DEP [NI] = '{3, 2, 4, 1, 5, 1};
  localparam int RRP [NI] = '{0, 1, 1, 0, 1, 1};
  localparam logic [31:0] RD = 32'hDEAD_BEEF;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0;
  logic in_valid [NI], out_ready [NI];
  logic [31:0] in_data [NI], out_data [NI];
  logic [NI-1:0] in_ready, out_valid;
  logic [3:0] occ [NI];
  int n_chk = 0, n_fail = 0;
  int cnt [NI];
  int mp [NI][8];
  logic [31:0] md [NI][8];
  logic [31:0] rx [8];
  bit armed = 1'b0;
  logic ev;
  always #5 clk = ~clk;
  for (genvar g = 0; g < NI; g++) begin : g_dut
    logic [$clog2(DEP[g]+2)-1:0] occ_w;
    pipe_reg_elastic #(.WIDTH(32), .DEPTH(DEP[g]), .REG_READY(RRP[g]), .RST_DATA(RD)) u_dut (
      .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid[g]), .in_data(in_data[g]),
      .in_ready(in_ready[g]), .out_valid(out_valid[g]), .out_data(out_data[g]),
      .out_ready(out_ready[g]), .occupancy(occ_w));
    assign occ[g] = 4'(occ_w);
  end
  task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d] got=%h exp=%h t=%0t", nm, k, act, exp, $time);
    end
  endtask
  // Model: beats oldest-first with a position (-1 = skid, DEPTH-1 = output stage).
  // Each beat steps forward one place if the slot ahead is free after the beat ahead moved.
  function automatic int tail_lim(int k);
    int lim = DEP[k] - 1, s = 0, np;
    if (cnt[k] > 0 && mp[k][0] == DEP[k] - 1 && out_ready[k]) s = 1;
    for (int i = s; i < cnt[k]; i++) begin
      np = mp[k][i] < lim ? mp[k][i] + 1 : mp[k][i];
      lim = np - 1;
    end
    return lim;
  endfunction
  function automatic logic exp_rdy(int k);
    if (rst || flush) return 1'b0;
    if (RRP[k] != 0) return !(cnt[k] > 0 && mp[k][cnt[k]-1] == -1);
    return tail_lim(k) >= 0;
  endfunction
  task automatic model_step(int k);
    logic ir, ox;
    int lim, np;
    ir = exp_rdy(k);
    ox = cnt[k] > 0 && mp[k][0] == DEP[k] - 1 && out_ready[k];
    if (rst || flush) begin
      cnt[k] = 0;
      return;
    end
    if (ox) begin
      for (int i = 1; i < cnt[k]; i++) begin
        mp[k][i-1] = mp[k][i];
        md[k][i-1] = md[k][i];
      end
      cnt[k]--;
    end
    lim = DEP[k] - 1;
    for (int i = 0; i < cnt[k]; i++) begin
      np = mp[k][i] < lim ? mp[k][i] + 1 : mp[k][i];
      mp[k][i] = np;
      lim = np - 1;
    end
    if (in_valid[k] && ir) begin
      mp[k][cnt[k]] = lim >= 0 ? 0 : -1;
      md[k][cnt[k]] = in_data[k];
      cnt[k]++;
    end
  endtask
  always @(negedge clk) begin
    for (int k = 0; k < NI; k++) begin
      if (armed) begin
        ev = cnt[k] > 0 && mp[k][0] == DEP[k] - 1;
        chk("in_ready", k, 32'(in_ready[k]), 32'(exp_rdy(k)));
        chk("out_valid", k, 32'(out_valid[k]), 32'(ev));
        if (ev) chk("out_data", k, out_data[k], md[k][0]);
        chk("occupancy", k, 32'(occ[k]), cnt[k]);
      end
      model_step(k);
    end
    if (rst) armed = 1'b1;
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  initial begin
    int n, got;
    logic acc;
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0;
      in_data[k] = '0;
      out_ready[k] = 1'b0;
      cnt[k] = 0;
    end
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk("rst_in_ready", k, 32'(in_ready[k]), 0);
      chk("rst_out_valid", k, 32'(out_valid[k]), 0);
      chk("rst_out_data", k, out_data[k], 32'hDEAD_BEEF);
      chk("rst_occ", k, 32'(occ[k]), 0);
    end
    tick;
    rst = 1'b0;
    @(negedge clk);
    for (int k = 0; k < NI; k++) chk("post_rst_ready", k, 32'(in_ready[k]), 1);
    tick;
    out_ready[0] = 1'b1;
    for (int j = 0; j < 13; j++) begin
      in_valid[0] = j < 10;
      in_data[0] = j + 1;
      @(negedge clk);
      if (j == 2) chk("stream_early", 0, 32'(out_valid[0]), 0);
      if (j >= 3) begin
        chk("stream_valid", 0, 32'(out_valid[0]), 1);
        chk("stream_data", 0, out_data[0], j - 2);
      end
      if (j >= 3 && j <= 10) chk("stream_occ", 0, 32'(occ[0]), 3);
      tick;
    end
    in_valid[1] = 1'b1;
    in_data[1] = 1;
    n = 1;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid[1] && out_ready[1] && got < 8) begin
        rx[got] = out_data[1];
        got++;
      end
      acc = in_valid[1] && in_ready[1];
      if (c == 3 || c == 5) chk("bp_hold", 1, out_data[1], 1);
      if (c == 4) begin
        chk("bp_ready", 1, 32'(in_ready[1]), 0);
        chk("bp_occ", 1, 32'(occ[1]), 3);
        chk("bp_valid", 1, 32'(out_valid[1]), 1);
      end
      tick;
      if (acc) n++;
      in_valid[1] = n <= 5;
      in_data[1] = n;
      if (c == 5) out_ready[1] = 1'b1;
    end
    chk("bp_count", 1, got, 5);
    for (int i = 0; i < 5; i++) chk("bp_order", 1, rx[i], i + 1);
    in_valid[2] = 1'b1;
    in_data[2] = 32'hA5;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (c == 0) chk("bub_ready", 2, 32'(in_ready[2]), 1);
      if (c == 3) chk("bub_early", 2, 32'(out_valid[2]), 0);
      if (c == 4) begin
        chk("bub_valid", 2, 32'(out_valid[2]), 1);
        chk("bub_data", 2, out_data[2], 32'hA5);
      end
      if (c == 9) begin
        chk("bub_occ", 2, 32'(occ[2]), 2);
        chk("bub_hold", 2, out_data[2], 32'hA5);
      end
      tick;
      in_valid[2] = c == 3;
      in_data[2] = 32'h5A;
    end
    out_ready[2] = 1'b1;
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1;
    in_data[0] = 11;
    tick;
    in_data[0] = 12;
    tick;
    in_data[0] = 13;
    tick;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("fl_full_occ", 0, 32'(occ[0]), 3);
    chk("fl_full_ready", 0, 32'(in_ready[0]), 0);
    chk("fl_head", 0, out_data[0], 11);
    tick;
    flush = 1'b1;
    in_valid[0] = 1'b1;
    in_data[0] = 99;
    out_ready[0] = 1'b1;
    @(negedge clk);
    chk("fl_ready", 0, 32'(in_ready[0]), 0);
    chk("fl_out_valid", 0, 32'(out_valid[0]), 1);
    tick;
    flush = 1'b0;
    in_data[0] = 7;
    @(negedge clk);
    chk("fl_after_valid", 0, 32'(out_valid[0]), 0);
    chk("fl_after_occ", 0, 32'(occ[0]), 0);
    chk("fl_after_ready", 0, 32'(in_ready[0]), 1);
    tick;
    in_valid[0] = 1'b0;
    @(negedge clk);
    chk("fl_b7_s0", 0, 32'(out_valid[0]), 0);
    tick;
    @(negedge clk);
    chk("fl_b7_s1", 0, 32'(out_valid[0]), 0);
    tick;
    @(negedge clk);
    chk("fl_b7_valid", 0, 32'(out_valid[0]), 1);
    chk("fl_b7_data", 0, out_data[0], 7);
    tick;
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < NI; k++) begin
        in_valid[k] = $urandom_range(0, 99) < 60;
        in_data[k] = $urandom;
        out_ready[k] = $urandom_range(0, 99) < (c < 2000 ? 40 : 70);
      end
      flush = $urandom_range(0, 499) == 0;
      tick;
    end
    flush = 1'b0;
    for (int k = 0; k < NI; k++) begin
      in_valid[k] = 1'b0;
      out_ready[k] = 1'b1;
    end
    repeat (10) tick;
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
